uart_rx: RTL and testbench

//  UART receiver for the class_based UART bench: the receive end of the link driven by the transmitter.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. The rx input is synchronised, oversampled by a baud-divided tick,
// and each bit is majority-voted from three samples around mid-bit.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          baud_divisor,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_tickk,
    output logic                 rx_busy,
    output logic                 frame_err
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] M0     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] M1     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] M2     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            div_q, div_d;
    logic [15:0]            dlat_q, dlat_d;
    logic [SW-1:0]          s_q, s_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   v0_q, v0_d, v1_q, v1_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    logic        rxs;
    logic [15:0] d_cur, d_eff;
    logic        tick, decide, wrap, bit_w;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign d_cur  = (baud_divisor == 16'd0) ? 16'd1 : baud_divisor;
    // The divisor follows the input while idle and is frozen for the whole frame.
    assign d_eff  = (state_q == IDLE) ? d_cur : dlat_q;
    assign tick   = (div_q == d_eff - 16'd1);
    assign decide = tick && (s_q == M2);
    assign wrap   = tick && (s_q == S_LAST);
    assign bit_w  = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);

    assign rx_data   = data_q;
    assign rx_ready  = ready_q;
    assign rx_tickk  = tick && reset;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = err_q;

    always_comb begin
        state_d = state_q;
        div_d   = (div_q >= d_eff - 16'd1) ? 16'd0 : div_q + 16'd1;
        s_d     = s_q;
        dlat_d  = dlat_q;
        idx_d   = idx_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        err_d   = 1'b0;

        if (tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == M0) v0_d = rxs;
            if (s_q == M1) v1_d = rxs;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    div_d   = 16'd0;
                    s_d     = '0;
                    dlat_d  = d_cur;
                end
            end
            START: begin
                if (decide && bit_w) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (decide) shift_d = {bit_w, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (idx_q == I_LAST) state_d = STOP;
                    else                 idx_d   = idx_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a following start bit be caught with no idle gap.
                if (decide) begin
                    if (bit_w) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= '1;
            div_q   <= 16'd0;
            dlat_q  <= 16'd1;
            s_q     <= '0;
            idx_q   <= '0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            div_q   <= div_d;
            dlat_q  <= dlat_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto rx and compares received bytes, pulses and
// timing against a byte-level model of what the transmitter sent.
module tb_uart_rx;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baud_divisor = 16'd4;
    logic        rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_ready, rx_tickk, rx_busy, frame_err;

    int checks = 0;
    int errors = 0;

    int         cyc = 0, ready_cnt = 0, ferr_cnt = 0, both_cnt = 0, tick_cnt = 0;
    int         ready_cyc = 0, start_cyc = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] model_data = 8'h00;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .baud_divisor(baud_divisor), .rx(rx),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_tickk(rx_tickk),
        .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (frame_err) ferr_cnt++;
        if (rx_ready && frame_err) both_cnt++;
        if (rx_tickk) tick_cnt++;
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Frame = start(0), 8 data bits LSB first, stop. cut>=0 truncates the frame;
    // spike_bit>=0 puts one tick of low centred on the M1 sample of that data bit.
    task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int d,
                               input int cut, input int spike_bit, input int new_baud);
        int         bp;
        logic [9:0] fr;
        bp = OS * d;
        fr = {stop_v, b, 1'b0};
        for (int c = 0; c < 10 * bp; c++) begin
            int   bi;
            int   off;
            logic v;
            if (cut >= 0 && c >= cut) break;
            bi = c / bp;
            off = c % bp;
            v = fr[bi];
            if (bi == spike_bit + 1 && off >= (OS/2)*d + d/2 && off < (OS/2)*d + d/2 + d) v = 1'b0;
            @(negedge clk);
            rx = v;
            if (c == 0) start_cyc = cyc;
            if (new_baud >= 0 && c == bp / 2) baud_divisor = 16'(new_baud);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        baud_divisor = 16'd0;
        repeat (5) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        checks++; if (rx_tickk !== 1'b0) begin errors++; $display("FAIL reset_rx_tickk: got %b expected 0", rx_tickk); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        @(negedge clk);
        reset = 1'b1;
        model_data = 8'h00;
        idle_cycles(8);
    endtask

    task automatic test_divider();
        int base;
        baud_divisor = 16'd0;
        idle_cycles(8);
        base = tick_cnt;
        idle_cycles(32);
        checks++; if (tick_cnt - base !== 32) begin errors++; $display("FAIL tick_div0: got %0d ticks expected 32", tick_cnt - base); end
        baud_divisor = 16'd5;
        idle_cycles(12);
        base = tick_cnt;
        idle_cycles(50);
        checks++; if (tick_cnt - base !== 10) begin errors++; $display("FAIL tick_div5: got %0d ticks expected 10", tick_cnt - base); end
        baud_divisor = 16'd4;
        idle_cycles(16);
    endtask

    task automatic test_basic();
        int r0, e0, lat;
        r0 = ready_cnt;
        e0 = ferr_cnt;
        drive_frame(8'hA5, 1'b1, 4, -1, -1, -1);
        idle_cycles(2 * OS * 4);
        checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL basic_ready_count: got %0d expected 1", ready_cnt - r0); end
        checks++; if (got_q.size() < r0 + 1 || got_q[r0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cnt - e0); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", rx_busy); end
        // Expected latency about 9*16*4 + 9*4 + 2 + 1 = 615 clk after the falling edge.
        lat = ready_cyc - start_cyc;
        checks++; if (lat < 615 || lat > 623) begin errors++; $display("FAIL basic_latency: got %0d clk expected 615..623", lat); end
        model_data = 8'hA5;
    endtask

    task automatic test_random();
        int         r0, e0, n;
        logic [7:0] exp_q[$];
        r0 = ready_cnt;
        e0 = ferr_cnt;
        n = 5;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            int         d;
            b = 8'($urandom);
            d = $urandom_range(2, 6);
            baud_divisor = 16'(d);
            idle_cycles($urandom_range(1, 40));
            // The divisor is scrambled mid-start-bit; the frame must keep its latched rate.
            drive_frame(b, 1'b1, d, -1, -1, $urandom_range(1, 9));
            exp_q.push_back(b);
        end
        baud_divisor = 16'd4;
        idle_cycles(2 * OS * 4);
        checks++; if (ready_cnt - r0 !== n) begin errors++; $display("FAIL random_ready_count: got %0d expected %0d", ready_cnt - r0, n); end
        for (int i = 0; i < n; i++) begin
            logic [7:0] g;
            g = (got_q.size() > r0 + i) ? got_q[r0 + i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL random_data_%0d: got %h expected %h", i, g, exp_q[i]); end
        end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL random_frame_err: got %0d expected 0", ferr_cnt - e0); end
        model_data = exp_q[n-1];
    endtask

    task automatic test_glitch();
        int r0, e0;
        r0 = ready_cnt;
        e0 = ferr_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 3 * 4; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle_cycles(2 * OS * 4);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_rose: got %b expected 1", busy_seen); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fell: got %b expected 0", rx_busy); end
        checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_ready: got %0d expected 0", ready_cnt - r0); end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - e0); end
        checks++; if (rx_data !== model_data) begin errors++; $display("FAIL glitch_data: got %h expected %h", rx_data, model_data); end
    endtask

    task automatic test_frame_err();
        int r0, e0;
        r0 = ready_cnt;
        e0 = ferr_cnt;
        drive_frame(8'h3C, 1'b0, 4, -1, -1, -1);
        for (int i = 0; i < 3 * OS * 4; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b expected 1", rx_busy); end
        checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - e0); end
        checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL ferr_ready: got %0d expected 0", ready_cnt - r0); end
        checks++; if (rx_data !== model_data) begin errors++; $display("FAIL ferr_data_held: got %h expected %h", rx_data, model_data); end
        idle_cycles(2 * OS * 4);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_recover: got %b expected 0", rx_busy); end
        checks++; if (ready_cnt - r0 !== 0 || ferr_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_no_new_frame: got %0d ready %0d err expected 0 and 1", ready_cnt - r0, ferr_cnt - e0); end
    endtask

    task automatic test_spike();
        int r0;
        r0 = ready_cnt;
        drive_frame(8'hFF, 1'b1, 4, -1, 1, -1);
        idle_cycles(2 * OS * 4);
        checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL spike_ready: got %0d expected 1", ready_cnt - r0); end
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL spike_data: got %h expected ff", rx_data); end
        model_data = 8'hFF;
    endtask

    task automatic test_back_to_back();
        int         r0, e0;
        logic [7:0] g0, g1;
        r0 = ready_cnt;
        e0 = ferr_cnt;
        drive_frame(8'h00, 1'b1, 4, -1, -1, -1);
        drive_frame(8'hFF, 1'b1, 4, -1, -1, -1);
        idle_cycles(2 * OS * 4);
        g0 = (got_q.size() > r0) ? got_q[r0] : 8'hxx;
        g1 = (got_q.size() > r0 + 1) ? got_q[r0 + 1] : 8'hxx;
        checks++; if (ready_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_ready_count: got %0d expected 2", ready_cnt - r0); end
        checks++; if (g0 !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", g0); end
        checks++; if (g1 !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", g1); end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cnt - e0); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ready_err_overlap: got %0d expected 0", both_cnt); end
        model_data = 8'hFF;
    endtask

    task automatic test_reset_midframe();
        int r0, e0;
        drive_frame(8'hC3, 1'b1, 4, 5 * OS * 4 + OS * 2, -1, -1);
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", rx_busy); end
        checks++; if (rx_ready !== 1'b0 || frame_err !== 1'b0 || rx_tickk !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses: got %b%b%b expected 000", rx_ready, frame_err, rx_tickk); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        model_data = 8'h00;
        idle_cycles(2 * OS * 4);
        r0 = ready_cnt;
        e0 = ferr_cnt;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0", rx_busy); end
        drive_frame(8'h5A, 1'b1, 4, -1, -1, -1);
        idle_cycles(2 * OS * 4);
        checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL rst_mid_ready: got %0d expected 1", ready_cnt - r0); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rst_mid_after: got %h expected 5a", rx_data); end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL rst_mid_frame_err: got %0d expected 0", ferr_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_basic();
        test_random();
        test_glitch();
        test_frame_err();
        test_spike();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
